// File: rtl/slot_scanner.sv
// Parking-slot scanner: synchronizes and debounces slot sensors, then
// counts occupied/free slots in a serial scan started by each tick.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   sensor - raw slot sensors (1 = busy), asynchronous to clk
//   tick   - one-clk sample-enable pulse
//   free   - registered free-slot count
//   busy   - registered occupied-slot count
//   valid  - one-clk pulse in the cycle after free/busy update
//   full   - registered, high when free == 0
module slot_scanner #(
   parameter int N_SLOTS   = 9,
   parameter int DEB_TICKS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_SLOTS-1:0] sensor,
   input  logic               tick,
   output logic [3:0]         free,
   output logic [3:0]         busy,
   output logic               valid,
   output logic               full
);

   localparam logic [3:0] NS       = 4'(N_SLOTS);
   localparam logic [3:0] LAST_IDX = 4'(N_SLOTS - 1);
   localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   // synchronizer and debounce state
   logic [N_SLOTS-1:0] sync1_q, sync1_d;
   logic [N_SLOTS-1:0] sync2_q, sync2_d;
   logic [N_SLOTS-1:0] deb_q, deb_d;
   logic [3:0]         cnt_q [N_SLOTS];
   logic [3:0]         cnt_d [N_SLOTS];

   // scan FSM state
   state_t     st_q, st_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] acc_q, acc_d;
   logic       pend_q, pend_d;
   logic       upd_q, upd_d;
   logic [3:0] free_q, free_d;
   logic [3:0] busy_q, busy_d;
   logic       full_q, full_d;
   logic       valid_q, valid_d;
   logic       sel_bit;

   always_comb begin
      sync1_d = sensor;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      for (int i = 0; i < N_SLOTS; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (tick) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == DEB_LAST) begin
               // DEB_TICKS-th consecutive disagreement: accept change
               deb_d[i] = ~deb_q[i];
               cnt_d[i] = 4'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         for (int i = 0; i < N_SLOTS; i++) begin
            cnt_q[i] <= 4'd0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         for (int i = 0; i < N_SLOTS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // debounced bit at the current scan index
   always_comb begin
      sel_bit = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (idx_q == 4'(i)) begin
            sel_bit = deb_q[i];
         end
      end
   end

   always_comb begin
      st_d    = st_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      pend_d  = pend_q;
      free_d  = free_q;
      busy_d  = busy_q;
      full_d  = full_q;
      upd_d   = 1'b0;
      // valid trails the output update by one cycle
      valid_d = upd_q;
      unique case (st_q)
         IDLE: begin
            if (tick) begin
               st_d   = SCAN;
               idx_d  = 4'd0;
               acc_d  = 4'd0;
               pend_d = 1'b0;
            end
         end
         SCAN: begin
            acc_d = acc_q + {3'b000, sel_bit};
            idx_d = idx_q + 4'd1;
            if (tick) begin
               pend_d = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
               st_d = PUBLISH;
            end
         end
         PUBLISH: begin
            busy_d = acc_q;
            free_d = NS - acc_q;
            full_d = (acc_q == NS);
            upd_d  = 1'b1;
            // a tick arriving right now counts as pending
            if (pend_q || tick) begin
               st_d   = SCAN;
               idx_d  = 4'd0;
               acc_d  = 4'd0;
               pend_d = 1'b0;
            end else begin
               st_d = IDLE;
            end
         end
         default: begin
            st_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= IDLE;
         idx_q   <= 4'd0;
         acc_q   <= 4'd0;
         pend_q  <= 1'b0;
         upd_q   <= 1'b0;
         free_q  <= NS;
         busy_q  <= 4'd0;
         full_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         pend_q  <= pend_d;
         upd_q   <= upd_d;
         free_q  <= free_d;
         busy_q  <= busy_d;
         full_q  <= full_d;
         valid_q <= valid_d;
      end
   end

   assign free  = free_q;
   assign busy  = busy_q;
   assign full  = full_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_slot_scanner.sv
// Directed bench for slot_scanner (N_SLOTS = 9, DEB_TICKS = 4).
// Table-driven debounce/count vectors plus hand-written FSM corner cases.
module tb_slot_scanner;

   logic       clk;
   logic       rst;
   logic [8:0] sensor;
   logic       tick;
   logic [3:0] free;
   logic [3:0] busy;
   logic       valid;
   logic       full;

   int nvec;
   int errs;

   slot_scanner #(
      .N_SLOTS  (9),
      .DEB_TICKS(4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sensor(sensor),
      .tick  (tick),
      .free  (free),
      .busy  (busy),
      .valid (valid),
      .full  (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] sensor;
      int         ticks;
      int         busy;
      int         free;
      int         full;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic settle(input logic [8:0] v);
      @(negedge clk);
      sensor = v;
      repeat (3) @(negedge clk);
   endtask

   // one tick from IDLE; waits for the valid pulse and checks latency
   task automatic run_scan();
      int lat;
      bit got;
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      lat = 0;
      got = 0;
      while (!got && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
         if (valid) got = 1;
      end
      chk("latency", lat, 11);
      @(posedge clk);
      #1;
      chk("valid_width", int'(valid), 0);
   endtask

   // ticks on the marked negedges after an initial IDLE tick; counts valids
   task automatic tick_burst(input logic [63:0] mask, output int pulses);
      pulses = 0;
      @(negedge clk);
      tick = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (valid) pulses++;
         tick = mask[c];
      end
      tick = 1'b0;
   endtask

   initial begin
      int np;
      nvec   = 0;
      errs   = 0;
      rst    = 1'b1;
      sensor = '0;
      tick   = 1'b0;

      tbl[0] = '{9'h000, 1, 0, 9, 0};
      tbl[1] = '{9'h007, 3, 0, 9, 0};
      tbl[2] = '{9'h007, 1, 3, 6, 0};
      tbl[3] = '{9'h007, 1, 3, 6, 0};
      tbl[4] = '{9'h1FF, 4, 9, 0, 1};
      tbl[5] = '{9'h000, 4, 0, 9, 0};
      tbl[6] = '{9'h155, 4, 5, 4, 0};
      tbl[7] = '{9'h0AA, 4, 4, 5, 0};
      tbl[8] = '{9'h100, 4, 1, 8, 0};

      #1;
      chk("rst_free", int'(free), 9);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_full", int'(full), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 9; v++) begin
         settle(tbl[v].sensor);
         for (int t = 0; t < tbl[v].ticks; t++) begin
            run_scan();
         end
         chk($sformatf("v%0d_busy", v), int'(busy), tbl[v].busy);
         chk($sformatf("v%0d_free", v), int'(free), tbl[v].free);
         chk($sformatf("v%0d_full", v), int'(full), tbl[v].full);
         chk($sformatf("v%0d_sum", v), int'(free) + int'(busy), 9);
      end

      // slot 0 glitch 1,1,1,0,1: never four in a row, stays free
      begin
         logic [4:0] g;
         g = 5'b10111;
         for (int k = 0; k < 5; k++) begin
            settle(9'h100 | {8'h00, g[k]});
            run_scan();
            chk($sformatf("glitch%0d_busy", k), int'(busy), 1);
         end
      end
      settle(9'h100);
      run_scan();
      chk("glitch_end_busy", int'(busy), 1);

      // three ticks during one scan collapse into one extra scan
      tick_burst(64'h54, np);
      chk("multi_tick_valids", np, 2);

      // tick in the PUBLISH cycle starts a new scan
      tick_burst(64'h200, np);
      chk("publish_tick_valids", np, 2);
      chk("publish_tick_busy", int'(busy), 1);

      // reset at scan index 4
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_busy", int'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midscan_rst_free", int'(free), 9);
      chk("midscan_rst_busy", int'(busy), 0);
      chk("midscan_rst_valid", int'(valid), 0);
      chk("midscan_rst_full", int'(full), 0);
      @(negedge clk);
      rst = 1'b0;
      np = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (valid) np++;
      end
      chk("post_rst_valids", np, 0);

      // reset cleared debounced bits: one tick is not enough to re-accept
      run_scan();
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_free", int'(free), 9);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
